// File: rtl/park_exit_release.sv
`default_nettype none
// ============================================================================
// Module   : park_exit_release
// Purpose  : Owns the 8-slot free bitmap. Applies entry occupies and handshaked
//            exit releases, keeps the free count and times the exit gate pulse.
// Revision : 1.0 - initial release
// ============================================================================
module park_exit_release #(
    parameter int GATE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       occupy_valid,
    input  logic [2:0] occupy_slot,
    input  logic       exit_valid,
    input  logic [2:0] exit_slot,
    output logic       exit_ready,
    output logic [7:0] parking_capacity,
    output logic [3:0] free_count,
    output logic       gate_open,
    output logic       occupy_err,
    output logic       release_err
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_check = 2'd1;
    localparam logic [1:0] c_st_gate  = 2'd2;
    localparam logic [3:0] c_gate_cycles = 4'(GATE_CYCLES);

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic [2:0] r_slot;
    logic [2:0] w_slot_nxt;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;

    logic       w_exit_ready_nxt;
    logic       w_gate_open_nxt;
    logic       w_rel_set;
    logic       w_rel_err;
    logic       w_occ_clr;
    logic       w_occ_err;
    logic [7:0] w_set_mask;
    logic [7:0] w_clr_mask;
    logic [7:0] w_cap_nxt;
    logic [3:0] w_count_nxt;

    // State, latched slot, counter and every output are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= c_st_idle;
            r_slot           <= 3'd0;
            r_cnt            <= 4'd0;
            exit_ready       <= 1'b1;
            gate_open        <= 1'b0;
            parking_capacity <= 8'hFF;
            free_count       <= 4'd8;
            occupy_err       <= 1'b0;
            release_err      <= 1'b0;
        end else begin
            r_state          <= w_state_nxt;
            r_slot           <= w_slot_nxt;
            r_cnt            <= w_cnt_nxt;
            exit_ready       <= w_exit_ready_nxt;
            gate_open        <= w_gate_open_nxt;
            parking_capacity <= w_cap_nxt;
            free_count       <= w_count_nxt;
            occupy_err       <= w_occ_err;
            release_err      <= w_rel_err;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_slot_nxt  = r_slot;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            c_st_idle: begin
                if (exit_valid && exit_ready) begin
                    w_slot_nxt  = exit_slot;
                    w_state_nxt = c_st_check;
                end
            end
            c_st_check: begin
                if (!parking_capacity[r_slot]) begin
                    w_cnt_nxt   = c_gate_cycles;
                    w_state_nxt = c_st_gate;
                end else begin
                    w_state_nxt = c_st_idle;
                end
            end
            c_st_gate: begin
                if (r_cnt <= 4'd1) begin
                    w_state_nxt = c_st_idle;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    // Both paths judge against the pre-edge bitmap, so a release set and an
    // occupy clear can never hit the same bit in one cycle.
    always_comb begin
        w_exit_ready_nxt = (w_state_nxt == c_st_idle);
        w_gate_open_nxt  = (w_state_nxt == c_st_gate);
        w_rel_set  = (r_state == c_st_check) && !parking_capacity[r_slot];
        w_rel_err  = (r_state == c_st_check) &&  parking_capacity[r_slot];
        w_occ_clr  = occupy_valid &&  parking_capacity[occupy_slot];
        w_occ_err  = occupy_valid && !parking_capacity[occupy_slot];
        w_set_mask = {7'd0, w_rel_set} << r_slot;
        w_clr_mask = {7'd0, w_occ_clr} << occupy_slot;
        w_cap_nxt  = (parking_capacity | w_set_mask) & ~w_clr_mask;
        case ({w_rel_set, w_occ_clr})
            2'b10:   w_count_nxt = free_count + 4'd1;
            2'b01:   w_count_nxt = free_count - 4'd1;
            default: w_count_nxt = free_count;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_park_exit_release.sv
`default_nettype none
// ============================================================================
// Module   : tb_park_exit_release
// Purpose  : Directed scenarios plus randomized traffic against a slot model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_park_exit_release;

    localparam int G = 4;

    logic       clk;
    logic       rst_n;
    logic       occupy_valid;
    logic [2:0] occupy_slot;
    logic       exit_valid;
    logic [2:0] exit_slot;
    logic       exit_ready;
    logic [7:0] parking_capacity;
    logic [3:0] free_count;
    logic       gate_open;
    logic       occupy_err;
    logic       release_err;

    int n_cmp;
    int n_fail;

    park_exit_release #(.GATE_CYCLES(G)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .occupy_valid     (occupy_valid),
        .occupy_slot      (occupy_slot),
        .exit_valid       (exit_valid),
        .exit_slot        (exit_slot),
        .exit_ready       (exit_ready),
        .parking_capacity (parking_capacity),
        .free_count       (free_count),
        .gate_open        (gate_open),
        .occupy_err       (occupy_err),
        .release_err      (release_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic occupy_one(input int s);
        occupy_valid = 1'b1;
        occupy_slot  = 3'(s);
        tick();
        occupy_valid = 1'b0;
    endtask

    task automatic start_release(input int s);
        exit_valid = 1'b1;
        exit_slot  = 3'(s);
        tick();
        exit_valid = 1'b0;
    endtask

    task automatic wait_ready(output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (exit_ready) begin
                timed_out = 1'b0;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        occupy_valid = 1'b0; occupy_slot = 3'd0;
        exit_valid = 1'b0;   exit_slot = 3'd0;
        #23;
        n_cmp++;
        if ({parking_capacity, free_count, exit_ready, gate_open, occupy_err, release_err}
            !== {8'hFF, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: got cap=%h cnt=%0d rdy=%b gate=%b oerr=%b rerr=%b, need cap=ff cnt=8 rdy=1 gate=0 oerr=0 rerr=0",
                     parking_capacity, free_count, exit_ready, gate_open, occupy_err, release_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_occupy();
        int errs = 0;
        occupy_one(0); errs += int'(occupy_err);
        occupy_one(1); errs += int'(occupy_err);
        occupy_one(5); errs += int'(occupy_err);
        n_cmp++;
        if (parking_capacity !== 8'b11011100 || free_count !== 4'd5 || errs != 0) begin
            n_fail++;
            $display("FAIL occupy_basic: got cap=%b cnt=%0d errs=%0d, need cap=11011100 cnt=5 errs=0",
                     parking_capacity, free_count, errs);
        end
    endtask

    task automatic test_release();
        int gate_hi = 0;
        int low = 0;
        bit done = 1'b0;
        start_release(5);
        n_cmp++;
        if (exit_ready !== 1'b0 || parking_capacity !== 8'b11011100) begin
            n_fail++;
            $display("FAIL release_accept: got rdy=%b cap=%b, need rdy=0 cap=11011100", exit_ready, parking_capacity);
        end
        low = 1;
        tick();
        n_cmp++;
        if (parking_capacity !== 8'b11111100 || free_count !== 4'd6 || gate_open !== 1'b1) begin
            n_fail++;
            $display("FAIL release_commit: got cap=%b cnt=%0d gate=%b, need cap=11111100 cnt=6 gate=1",
                     parking_capacity, free_count, gate_open);
        end
        gate_hi = 1; low = 2;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (exit_ready) begin
                done = 1'b1;
                break;
            end
            low++;
            if (gate_open) gate_hi++;
        end
        n_cmp++;
        if (!done || gate_hi != G || low != G + 1 || gate_open !== 1'b0) begin
            n_fail++;
            $display("FAIL release_timing: got gate_cycles=%0d ready_low=%0d done=%b, need gate_cycles=%0d ready_low=%0d done=1",
                     gate_hi, low, done, G, G + 1);
        end
    endtask

    task automatic test_bad_inputs();
        start_release(7);
        tick();
        n_cmp++;
        if (release_err !== 1'b1 || gate_open !== 1'b0 || exit_ready !== 1'b1 || parking_capacity !== 8'b11111100) begin
            n_fail++;
            $display("FAIL release_free_slot: got rerr=%b gate=%b rdy=%b cap=%b, need rerr=1 gate=0 rdy=1 cap=11111100",
                     release_err, gate_open, exit_ready, parking_capacity);
        end
        tick();
        n_cmp++;
        if (release_err !== 1'b0 || gate_open !== 1'b0) begin
            n_fail++;
            $display("FAIL release_err_pulse: got rerr=%b gate=%b, need rerr=0 gate=0", release_err, gate_open);
        end
        occupy_one(0);
        n_cmp++;
        if (occupy_err !== 1'b1 || free_count !== 4'd6 || parking_capacity !== 8'b11111100) begin
            n_fail++;
            $display("FAIL occupy_taken_slot: got oerr=%b cnt=%0d cap=%b, need oerr=1 cnt=6 cap=11111100",
                     occupy_err, free_count, parking_capacity);
        end
        tick();
        n_cmp++;
        if (occupy_err !== 1'b0) begin
            n_fail++;
            $display("FAIL occupy_err_pulse: got oerr=%b, need 0", occupy_err);
        end
    endtask

    task automatic test_full_lot();
        int errs = 0;
        for (int s = 2; s < 8; s++) begin
            occupy_one(s);
            errs += int'(occupy_err);
        end
        n_cmp++;
        if (parking_capacity !== 8'h00 || free_count !== 4'd0 || errs != 0) begin
            n_fail++;
            $display("FAIL full_lot: got cap=%h cnt=%0d errs=%0d, need cap=00 cnt=0 errs=0",
                     parking_capacity, free_count, errs);
        end
        occupy_one(3);
        n_cmp++;
        if (occupy_err !== 1'b1 || free_count !== 4'd0 || parking_capacity !== 8'h00) begin
            n_fail++;
            $display("FAIL full_lot_overflow: got oerr=%b cnt=%0d cap=%h, need oerr=1 cnt=0 cap=00",
                     occupy_err, free_count, parking_capacity);
        end
        tick();
    endtask

    task automatic test_collision();
        bit to;
        start_release(2);
        occupy_valid = 1'b1; occupy_slot = 3'd2;
        tick();
        occupy_valid = 1'b0;
        n_cmp++;
        if (parking_capacity !== 8'b00000100 || occupy_err !== 1'b1 || free_count !== 4'd1) begin
            n_fail++;
            $display("FAIL collision_same: got cap=%b oerr=%b cnt=%0d, need cap=00000100 oerr=1 cnt=1",
                     parking_capacity, occupy_err, free_count);
        end
        wait_ready(to);
        start_release(4);
        tick();
        wait_ready(to);
        occupy_one(2);
        n_cmp++;
        if (to || parking_capacity !== 8'b00010000 || free_count !== 4'd1) begin
            n_fail++;
            $display("FAIL collision_setup: got cap=%b cnt=%0d timeout=%b, need cap=00010000 cnt=1 timeout=0",
                     parking_capacity, free_count, to);
        end
        start_release(2);
        occupy_valid = 1'b1; occupy_slot = 3'd4;
        tick();
        occupy_valid = 1'b0;
        n_cmp++;
        if (parking_capacity !== 8'b00000100 || occupy_err !== 1'b0 || free_count !== 4'd1) begin
            n_fail++;
            $display("FAIL collision_diff: got cap=%b oerr=%b cnt=%0d, need cap=00000100 oerr=0 cnt=1",
                     parking_capacity, occupy_err, free_count);
        end
        wait_ready(to);
        n_cmp++;
        if (to) begin
            n_fail++;
            $display("FAIL collision_ready: got timeout, need exit_ready within budget");
        end
    endtask

    task automatic test_reset_in_gate();
        bit to;
        start_release(0);
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (gate_open !== 1'b0 || parking_capacity !== 8'hFF || free_count !== 4'd8 || exit_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_gate: got gate=%b cap=%h cnt=%0d rdy=%b, need gate=0 cap=ff cnt=8 rdy=1",
                     gate_open, parking_capacity, free_count, exit_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        occupy_one(6);
        start_release(6);
        tick();
        n_cmp++;
        if (parking_capacity !== 8'hFF || free_count !== 4'd8 || gate_open !== 1'b1) begin
            n_fail++;
            $display("FAIL release_after_reset: got cap=%h cnt=%0d gate=%b, need cap=ff cnt=8 gate=1",
                     parking_capacity, free_count, gate_open);
        end
        wait_ready(to);
        n_cmp++;
        if (to) begin
            n_fail++;
            $display("FAIL release_after_reset_ready: got timeout, need exit_ready within budget");
        end
    endtask

    // Reference: per-slot free flags plus the release timeline
    // (pending check, then G cycles of gate, then idle again).
    task automatic test_random();
        bit   slot_free[8];
        bit   pre[8];
        bit   pending;
        int   pend_slot;
        int   gate_left;
        bit   can_accept;
        bit   e_oerr, e_rerr;
        bit   ov, ev;
        int   os, es;
        logic [7:0] e_cap;
        int   e_cnt;

        rst_n = 1'b0;
        #3;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) slot_free[i] = 1'b1;
        pending = 1'b0; pend_slot = 0; gate_left = 0;

        for (int cyc = 0; cyc < 400; cyc++) begin
            ov = ($urandom_range(0, 2) != 0);
            os = $urandom_range(0, 7);
            ev = $urandom_range(0, 1) == 1;
            es = $urandom_range(0, 7);
            occupy_valid = ov; occupy_slot = 3'(os);
            exit_valid   = ev; exit_slot   = 3'(es);

            pre = slot_free;
            can_accept = !pending && gate_left == 0;
            e_oerr = 1'b0; e_rerr = 1'b0;
            if (pending) begin
                if (!pre[pend_slot]) begin
                    slot_free[pend_slot] = 1'b1;
                    gate_left = G;
                end else begin
                    e_rerr = 1'b1;
                end
                pending = 1'b0;
            end else if (gate_left > 0) begin
                gate_left--;
            end
            if (ev && can_accept) begin
                pending = 1'b1;
                pend_slot = es;
            end
            if (ov) begin
                if (pre[os]) slot_free[os] = 1'b0;
                else         e_oerr = 1'b1;
            end
            e_cnt = 0;
            for (int b = 0; b < 8; b++) begin
                e_cap[b] = slot_free[b];
                e_cnt += int'(slot_free[b]);
            end

            tick();
            n_cmp++;
            if (parking_capacity !== e_cap || free_count !== 4'(e_cnt)) begin
                n_fail++;
                $display("FAIL rand_bitmap cyc %0d: got cap=%b cnt=%0d, need cap=%b cnt=%0d",
                         cyc, parking_capacity, free_count, e_cap, e_cnt);
            end
            n_cmp++;
            if (exit_ready !== (!pending && gate_left == 0) || gate_open !== (gate_left > 0)) begin
                n_fail++;
                $display("FAIL rand_handshake cyc %0d: got rdy=%b gate=%b, need rdy=%b gate=%b",
                         cyc, exit_ready, gate_open, !pending && gate_left == 0, gate_left > 0);
            end
            n_cmp++;
            if (occupy_err !== e_oerr || release_err !== e_rerr) begin
                n_fail++;
                $display("FAIL rand_errors cyc %0d: got oerr=%b rerr=%b, need oerr=%b rerr=%b",
                         cyc, occupy_err, release_err, e_oerr, e_rerr);
            end
        end
        occupy_valid = 1'b0;
        exit_valid   = 1'b0;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_occupy();
        test_release();
        test_bad_inputs();
        test_full_lot();
        test_collision();
        test_reset_in_gate();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
